// File: rtl/adau_spi_arbiter.sv
// adau_spi_arbiter: shares the SPI master command port between the ADAU
// init command list (req 0) and the runtime parameter writer (req 1).
// Ports: clk, reset (async, active-high), init_done gates req 1;
//   cmd0/cmd0_valid/cmd0_last/cmd0_ready and cmd1/... request channels;
//   command/command_valid/spi_ready drive the SPI master through a
//   one-entry output register; grant is one-hot (00 idle);
//   burst_overrun is sticky, set when a burst is cut at MAX_BURST.
// Option: define ARB_ROUND_ROBIN_EN for round-robin priority between
//   bursts; otherwise req 0 has fixed priority.
module adau_spi_arbiter #(
  parameter int CMD_W     = 32,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_done,
  input  logic [CMD_W-1:0] cmd0,
  input  logic             cmd0_valid,
  input  logic             cmd0_last,
  output logic             cmd0_ready,
  input  logic [CMD_W-1:0] cmd1,
  input  logic             cmd1_valid,
  input  logic             cmd1_last,
  output logic             cmd1_ready,
  output logic [CMD_W-1:0] command,
  output logic             command_valid,
  input  logic             spi_ready,
  output logic [1:0]       grant,
  output logic             burst_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY0,
    BUSY1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CMD_W-1:0] acc_cmd;
  logic             slot_free;
  logic             acc0;
  logic             acc1;
  logic             acc;
  logic             acc_last;
  logic             at_max;
  logic             rel;
  logic             elig0;
  logic             elig1;
  logic             pick1;

  // Output slot can take a beat if empty or draining this cycle.
  assign slot_free  = !command_valid || spi_ready;
  assign cmd0_ready = (state == BUSY0) && slot_free;
  assign cmd1_ready = (state == BUSY1) && slot_free;

  assign acc0     = cmd0_valid && cmd0_ready;
  assign acc1     = cmd1_valid && cmd1_ready;
  assign acc      = acc0 || acc1;
  assign acc_cmd  = acc1 ? cmd1 : cmd0;
  assign acc_last = acc1 ? cmd1_last : cmd0_last;

  assign cnt_nxt = cnt + 1'b1;
  assign at_max  = (cnt_nxt == CNT_W'(MAX_BURST));
  assign rel     = acc && (acc_last || at_max);

  assign elig0 = cmd0_valid;
  assign elig1 = cmd1_valid && init_done;

`ifdef ARB_ROUND_ROBIN_EN
  // prio1: requester 1 holds priority for the next grant.
  logic prio1;

  assign pick1 = elig1 && (prio1 || !elig0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio1 <= 1'b0;
    end else if (rel) begin
      prio1 <= (state == BUSY0);
    end
  end
`else
  assign pick1 = elig1 && !elig0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 2'b00;
      cnt           <= '0;
      command       <= '0;
      command_valid <= 1'b0;
      burst_overrun <= 1'b0;
    end else begin
      if (acc) begin
        command       <= acc_cmd;
        command_valid <= 1'b1;
      end else if (spi_ready) begin
        command_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (pick1) begin
            state <= BUSY1;
            grant <= 2'b10;
          end else if (elig0) begin
            state <= BUSY0;
            grant <= 2'b01;
          end
        end
        BUSY0, BUSY1: begin
          if (rel) begin
            state <= IDLE;
            grant <= 2'b00;
            cnt   <= '0;
            if (!acc_last) begin
              burst_overrun <= 1'b1;
            end
          end else if (acc) begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adau_spi_arbiter.sv
// tb_adau_spi_arbiter: directed bench for adau_spi_arbiter.
// Table of IDLE arbitration cases plus burst, stall, overrun, reset runs.
module tb_adau_spi_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_done = 1'b0;
  logic        spi_ready = 1'b0;
  logic [31:0] cmd0 = '0;
  logic        cmd0_valid = 1'b0;
  logic        cmd0_last = 1'b0;
  logic        cmd0_ready;
  logic [31:0] cmd1 = '0;
  logic        cmd1_valid = 1'b0;
  logic        cmd1_last = 1'b0;
  logic        cmd1_ready;
  logic [31:0] command;
  logic        command_valid;
  logic [1:0]  grant;
  logic        burst_overrun;

  always #5 clk = ~clk;

  adau_spi_arbiter #(
    .CMD_W(32),
    .MAX_BURST(16),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init_done(init_done),
    .cmd0(cmd0),
    .cmd0_valid(cmd0_valid),
    .cmd0_last(cmd0_last),
    .cmd0_ready(cmd0_ready),
    .cmd1(cmd1),
    .cmd1_valid(cmd1_valid),
    .cmd1_last(cmd1_last),
    .cmd1_ready(cmd1_ready),
    .command(command),
    .command_valid(command_valid),
    .spi_ready(spi_ready),
    .grant(grant),
    .burst_overrun(burst_overrun)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  typedef struct {
    logic       init;
    logic       v0;
    logic       v1;
    logic [1:0] g;
  } row_t;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [31:0] out_q[$];
  logic [1:0]  glog[$];
  int          llog[$];

  int n_pass = 0;
  int n_tot = 0;
  int ready_viol = 0;
  int stab_viol = 0;
  int rel_viol = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic nb();
    @(negedge clk);
    #2;
  endtask

  // Requester sources: pop on handshake, present head of queue.
  always begin
    @(posedge clk);
    if (cmd0_valid && cmd0_ready && q0.size() > 0) void'(q0.pop_front());
    if (cmd1_valid && cmd1_ready && q1.size() > 0) void'(q1.pop_front());
    #1;
    cmd0_valid = q0.size() > 0;
    cmd0       = cmd0_valid ? q0[0].d : '0;
    cmd0_last  = cmd0_valid ? q0[0].l : 1'b0;
    cmd1_valid = q1.size() > 0;
    cmd1       = cmd1_valid ? q1[0].d : '0;
    cmd1_last  = cmd1_valid ? q1[0].l : 1'b0;
  end

  // Monitor: SPI sink log, grant/burst-length logs, protocol invariants.
  logic [1:0]  pg = 2'b00;
  int          cur_len = 0;
  bit          hold = 1'b0;
  bit          lhs = 1'b0;
  logic [31:0] hcmd = '0;
  always begin
    @(posedge clk);
    hold = !reset && command_valid && !spi_ready;
    hcmd = command;
    lhs  = !reset && ((cmd0_valid && cmd0_ready && cmd0_last) ||
                      (cmd1_valid && cmd1_ready && cmd1_last));
    if (!reset && ((cmd0_valid && cmd0_ready) ||
                   (cmd1_valid && cmd1_ready))) cur_len++;
    if (!reset && command_valid && spi_ready) out_q.push_back(command);
    @(negedge clk);
    if (!reset && hold && !(command_valid && command == hcmd)) stab_viol++;
    if (lhs && grant != 2'b00) rel_viol++;
    if ((cmd0_ready && grant != 2'b01) ||
        (cmd1_ready && grant != 2'b10)) ready_viol++;
    if (grant != 2'b00 && pg == 2'b00) glog.push_back(grant);
    if (grant == 2'b00 && pg != 2'b00) begin
      llog.push_back(cur_len);
      cur_len = 0;
    end
    pg = grant;
  end

  task automatic clear_logs();
    out_q.delete();
    glog.delete();
    llog.delete();
  endtask

  task automatic do_reset();
    nb();
    reset = 1'b1;
    nb();
    q0.delete();
    q1.delete();
    clear_logs();
    nb();
    nb();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input bit w0, input bit w1);
    int n = 0;
    while (((w0 && q0.size() != 0) || (w1 && q1.size() != 0) ||
            command_valid) && n < 500) begin
      nb();
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 500), 32'd1);
  endtask

  function automatic logic [31:0] oq(input int i);
    return (i < out_q.size()) ? out_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gq(input int i);
    return (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF;
  endfunction

  function automatic logic [31:0] lq(input int i);
    return (i < llog.size()) ? 32'(llog[i]) : 32'hFFFF;
  endfunction

  row_t        rows[8];
  logic [31:0] e3[8];
  logic [1:0]  g3[4];
  int          bad;

  initial begin
    rows[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    rows[1] = '{1'b0, 1'b0, 1'b1, 2'b00};
    rows[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    rows[3] = '{1'b0, 1'b1, 1'b1, 2'b01};
    rows[4] = '{1'b1, 1'b0, 1'b0, 2'b00};
    rows[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    rows[6] = '{1'b1, 1'b1, 1'b0, 2'b01};
    rows[7] = '{1'b1, 1'b1, 1'b1, 2'b01};
`ifdef ARB_ROUND_ROBIN_EN
    g3 = '{2'b01, 2'b10, 2'b01, 2'b10};
    e3 = '{32'hD0, 32'hD1, 32'hE0, 32'hE1,
           32'hD2, 32'hD3, 32'hE2, 32'hE3};
`else
    g3 = '{2'b01, 2'b01, 2'b10, 2'b10};
    e3 = '{32'hD0, 32'hD1, 32'hD2, 32'hD3,
           32'hE0, 32'hE1, 32'hE2, 32'hE3};
`endif

    spi_ready = 1'b1;
    nb();
    nb();
    chk("rst_cv", 32'(command_valid), 0);
    chk("rst_cmd", command, 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_rdy0", 32'(cmd0_ready), 0);
    chk("rst_rdy1", 32'(cmd1_ready), 0);
    chk("rst_ovr", 32'(burst_overrun), 0);

    // IDLE arbitration table: one request beat per row, fresh reset.
    for (int r = 0; r < 8; r++) begin
      reset = 1'b1;
      q0.delete();
      q1.delete();
      if (rows[r].v0) q0.push_back('{32'h11, 1'b1});
      if (rows[r].v1) q1.push_back('{32'h22, 1'b1});
      init_done = rows[r].init;
      nb();
      nb();
      reset = 1'b0;
      #1;
      chk($sformatf("arb%0d_idle_rdy0", r), 32'(cmd0_ready), 0);
      chk($sformatf("arb%0d_idle_rdy1", r), 32'(cmd1_ready), 0);
      nb();
      chk($sformatf("arb%0d_grant", r), 32'(grant), 32'(rows[r].g));
    end

    // 15-word req0 burst while req1 is held off by init_done=0.
    init_done = 1'b0;
    spi_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 15; i++) q0.push_back('{32'hA000_0000 + i, i == 14});
    q1.push_back('{32'hB0, 1'b0});
    q1.push_back('{32'hB1, 1'b1});
    wait_drain("t1", 1'b1, 1'b0);
    nb();
    nb();
    chk("t1_count", 32'(out_q.size()), 15);
    for (int i = 0; i < 15; i++)
      chk($sformatf("t1_word%0d", i), oq(i), 32'hA000_0000 + i);
    chk("t1_ngrant", 32'(glog.size()), 1);
    chk("t1_grant", gq(0), 32'h1);
    chk("t1_len", lq(0), 15);
    chk("t1_idle", 32'(grant), 0);

    // SPI stalls for 100 cycles with a word held.
    clear_logs();
    spi_ready = 1'b0;
    for (int i = 0; i < 5; i++) q0.push_back('{32'hC0 + i, i == 4});
    repeat (100) nb();
    chk("t2_cv", 32'(command_valid), 1);
    chk("t2_held", command, 32'hC0);
    chk("t2_rdy0", 32'(cmd0_ready), 0);
    chk("t2_grant", 32'(grant), 32'h1);
    chk("t2_none", 32'(out_q.size()), 0);
    spi_ready = 1'b1;
    nb();
    chk("t2_next", command, 32'hC1);
    chk("t2_first", oq(0), 32'hC0);
    wait_drain("t2", 1'b1, 1'b0);
    nb();
    bad = 0;
    for (int i = 0; i < 5; i++) if (oq(i) !== 32'hC0 + i) bad++;
    chk("t2_count", 32'(out_q.size()), 5);
    chk("t2_order", 32'(bad), 0);

    // Both requesters continuously with 2-word bursts.
    init_done = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{32'hD0 + i, i[0]});
      q1.push_back('{32'hE0 + i, i[0]});
    end
    wait_drain("t3", 1'b1, 1'b1);
    nb();
    nb();
    chk("t3_ngrant", 32'(glog.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_grant%0d", i), gq(i), 32'(g3[i]));
      chk($sformatf("t3_len%0d", i), lq(i), 2);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) if (oq(i) !== e3[i]) bad++;
    chk("t3_order", 32'(bad), 0);

    // 20 words without last: forced release after 16.
    do_reset();
    for (int i = 0; i < 20; i++) q1.push_back('{32'hF00 + i, 1'b0});
    wait_drain("t4", 1'b0, 1'b1);
    nb();
    nb();
    chk("t4_ovr", 32'(burst_overrun), 1);
    chk("t4_ngrant", 32'(glog.size()), 2);
    chk("t4_grant0", gq(0), 32'h2);
    chk("t4_grant1", gq(1), 32'h2);
    chk("t4_len", lq(0), 16);
    chk("t4_count", 32'(out_q.size()), 20);
    bad = 0;
    for (int i = 0; i < 20; i++) if (oq(i) !== 32'hF00 + i) bad++;
    chk("t4_order", 32'(bad), 0);
    repeat (10) nb();
    chk("t4_ovr_sticky", 32'(burst_overrun), 1);
    chk("t4_grant_held", 32'(grant), 32'h2);

    // Reset mid-burst with a word held in the output register.
    spi_ready = 1'b0;
    q1.push_back('{32'h700, 1'b0});
    q1.push_back('{32'h701, 1'b0});
    q1.push_back('{32'h702, 1'b0});
    repeat (4) nb();
    chk("t5_cv", 32'(command_valid), 1);
    chk("t5_cmd", command, 32'h700);
    reset = 1'b1;
    #1;
    chk("t5_rst_cv", 32'(command_valid), 0);
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_rdy0", 32'(cmd0_ready), 0);
    chk("t5_rst_rdy1", 32'(cmd1_ready), 0);
    chk("t5_rst_ovr", 32'(burst_overrun), 0);
    nb();
    nb();
    clear_logs();
    reset = 1'b0;
    spi_ready = 1'b1;
    q1.push_back('{32'h703, 1'b1});
    wait_drain("t5", 1'b0, 1'b1);
    nb();
    nb();
    chk("t5_count", 32'(out_q.size()), 3);
    chk("t5_w0", oq(0), 32'h701);
    chk("t5_w1", oq(1), 32'h702);
    chk("t5_w2", oq(2), 32'h703);
    chk("t5_grant", gq(0), 32'h2);
    chk("t5_len", lq(0), 3);
    chk("t5_ovr", 32'(burst_overrun), 0);
    chk("t5_idle", 32'(grant), 0);

    chk("ready_outside_grant", 32'(ready_viol), 0);
    chk("stall_stability", 32'(stab_viol), 0);
    chk("release_after_last", 32'(rel_viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
